// File: rtl/othello_turn_ctrl.sv
// Othello turn controller: owns the cursor and side to move, and turns debounced
// key pulses into a detect-then-write handshake with the board storage/flip block.
// Tracks accepted placements and consecutive passes and declares game over.
module othello_turn_ctrl #(
   parameter logic [1:0] START_SIDE = 2'd2,
   parameter int         MAX_PLACE  = 60
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       key_up,
   input  logic       key_down,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       key_place,
   input  logic       key_pass,
   input  logic [1:0] q,
   input  logic [7:0] dir,
   output logic [2:0] x,
   output logic [2:0] y,
   output logic [1:0] side,
   output logic       detecten,
   output logic       writeen,
   output logic       busy,
   output logic       illegal,
   output logic       game_over,
   output logic [5:0] placed
);

   typedef enum logic [3:0] {
      IDLE, CHECK, DET0, DET1, EVAL, WR0, WR1, DONE, REJECT, GAMEOVER
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [1:0] pass_cnt;
   logic       last_place;

   // The placement that completes in DONE is the one that ends the game.
   assign last_place = (placed == 6'(MAX_PLACE - 1));

   // State register.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      if (resetn) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic: key priority place > pass > cursor; keys outside IDLE are dropped.
   always_comb begin
      // NOTE: the default assignment first keeps this block free of inferred latches.
      state_next = state;
      unique case (state)
         IDLE: begin
            if (key_place)                          state_next = CHECK;
            else if (key_pass && pass_cnt == 2'd1)  state_next = GAMEOVER;
         end
         CHECK:    state_next = (q != 2'b00) ? REJECT : DET0;
         DET0:     state_next = DET1;
         DET1:     state_next = EVAL;
         EVAL:     state_next = (dir == 8'h00) ? REJECT : WR0;
         WR0:      state_next = WR1;
         WR1:      state_next = DONE;
         DONE:     state_next = last_place ? GAMEOVER : IDLE;
         REJECT:   state_next = IDLE;
         GAMEOVER: state_next = GAMEOVER;
         default:  state_next = IDLE;
      endcase
   end

   // Moore output decode: strobes depend on the state register only.
   always_comb begin
      detecten  = 1'b0;
      writeen   = 1'b0;
      illegal   = 1'b0;
      game_over = 1'b0;
      busy      = 1'b1;
      unique case (state)
         IDLE:       busy      = 1'b0;
         DET0, DET1: detecten  = 1'b1;
         WR0, WR1:   writeen   = 1'b1;
         REJECT:     illegal   = 1'b1;
         GAMEOVER: begin
            busy      = 1'b0;
            game_over = 1'b1;
         end
         default: ;
      endcase
   end

   // Cursor, side, placement and pass bookkeeping.
   always_ff @(posedge clock) begin
      if (resetn) begin
         x        <= 3'd3;
         y        <= 3'd3;
         side     <= START_SIDE;
         placed   <= 6'd0;
         pass_cnt <= 2'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (key_place) begin
                  // cursor freezes for the whole placement sequence
               end else if (key_pass) begin
                  side     <= {1'b1, ~side[0]};
                  pass_cnt <= pass_cnt + 2'd1;
               end else if (key_up) begin
                  y <= y - 3'd1;
               end else if (key_down) begin
                  y <= y + 3'd1;
               end else if (key_left) begin
                  x <= x - 3'd1;
               end else if (key_right) begin
                  x <= x + 3'd1;
               end
            end
            DONE: begin
               side     <= {1'b1, ~side[0]};
               placed   <= placed + 6'd1;
               pass_cnt <= 2'd0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_othello_turn_ctrl.sv
// Self-checking bench for othello_turn_ctrl: a timeline-based model of the turn
// rules is compared against the DUT every cycle, and directed scenarios add
// hand-computed expectations for cursor wrap, placement timing, passes and reset.
module tb_othello_turn_ctrl;

   localparam int MAXP = 60;
   localparam logic [5:0] K_PLACE = 6'b100000;
   localparam logic [5:0] K_PASS  = 6'b010000;
   localparam logic [5:0] K_UP    = 6'b001000;
   localparam logic [5:0] K_DOWN  = 6'b000100;
   localparam logic [5:0] K_LEFT  = 6'b000010;
   localparam logic [5:0] K_RIGHT = 6'b000001;

   logic       clock = 1'b0;
   logic       resetn = 1'b1;
   logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
   logic       key_place = 1'b0, key_pass = 1'b0;
   logic [1:0] q = 2'd0;
   logic [7:0] dir = 8'h00;

   logic [2:0] x, y;
   logic [1:0] side;
   logic       detecten, writeen, busy, illegal, game_over;
   logic [5:0] placed;

   logic [2:0] x2, y2;
   logic [1:0] side2;
   logic       detecten2, writeen2, busy2, illegal2, game_over2;
   logic [5:0] placed2;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   othello_turn_ctrl #(.START_SIDE(2'd2), .MAX_PLACE(MAXP)) dut (
      .clock(clock), .resetn(resetn),
      .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
      .key_place(key_place), .key_pass(key_pass), .q(q), .dir(dir),
      .x(x), .y(y), .side(side), .detecten(detecten), .writeen(writeen),
      .busy(busy), .illegal(illegal), .game_over(game_over), .placed(placed)
   );

   othello_turn_ctrl #(.START_SIDE(2'd2), .MAX_PLACE(2)) dut2 (
      .clock(clock), .resetn(resetn),
      .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
      .key_place(key_place), .key_pass(key_pass), .q(q), .dir(dir),
      .x(x2), .y(y2), .side(side2), .detecten(detecten2), .writeen(writeen2),
      .busy(busy2), .illegal(illegal2), .game_over(game_over2), .placed(placed2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_t counts cycles since the place key was sampled (0 = waiting for keys);
   // m_kind: 0 = legal move, 1 = rejected occupied cell, 2 = rejected no flips.
   int m_x, m_y, m_side, m_placed, m_pass, m_t, m_kind;
   bit m_over;
   bit model_ok = 1'b0;

   // Model advances on the same edge the DUT samples its inputs.
   always @(posedge clock) begin
      if (resetn) begin
         m_x = 3; m_y = 3; m_side = 2; m_placed = 0; m_pass = 0;
         m_t = 0; m_kind = 0; m_over = 1'b0; model_ok = 1'b1;
      end else if (model_ok && !m_over) begin
         if (m_t == 0) begin
            if (key_place) begin
               m_t = 1; m_kind = 0;
            end else if (key_pass) begin
               m_side = 5 - m_side;
               m_pass = m_pass + 1;
               if (m_pass == 2) m_over = 1'b1;
            end else if (key_up)    m_y = (m_y + 7) % 8;
            else if (key_down)      m_y = (m_y + 1) % 8;
            else if (key_left)      m_x = (m_x + 7) % 8;
            else if (key_right)     m_x = (m_x + 1) % 8;
         end else if (m_t == 1) begin
            if (q != 2'd0) m_kind = 1;
            m_t = 2;
         end else if (m_kind == 1 && m_t == 2) begin
            m_t = 0;
         end else if (m_t == 4) begin
            if (dir == 8'h00) m_kind = 2;
            m_t = 5;
         end else if (m_kind == 2 && m_t == 5) begin
            m_t = 0;
         end else if (m_t == 7) begin
            m_side   = 5 - m_side;
            m_placed = m_placed + 1;
            m_pass   = 0;
            if (m_placed == MAXP) m_over = 1'b1;
            m_t = 0;
         end else begin
            m_t = m_t + 1;
         end
      end
   end

   // Every-cycle comparison of all DUT outputs against the model.
   always @(negedge clock) begin
      if (model_ok) begin
         check("cyc_x", 32'(x), 32'(m_x));
         check("cyc_y", 32'(y), 32'(m_y));
         check("cyc_side", 32'(side), 32'(m_side));
         check("cyc_placed", 32'(placed), 32'(m_placed));
         check("cyc_detecten", 32'(detecten), 32'((m_t == 2 || m_t == 3) && m_kind != 1));
         check("cyc_writeen", 32'(writeen), 32'((m_t == 5 || m_t == 6) && m_kind == 0));
         check("cyc_illegal", 32'(illegal),
               32'((m_kind == 1 && m_t == 2) || (m_kind == 2 && m_t == 5)));
         check("cyc_busy", 32'(busy), 32'(m_t != 0));
         check("cyc_game_over", 32'(game_over), 32'(m_over));
         check("cyc_det_wr_excl", 32'(detecten & writeen), 32'd0);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_keys(input logic [5:0] k);
      {key_place, key_pass, key_up, key_down, key_left, key_right} = k;
   endtask

   task automatic press(input logic [5:0] k);
      @(negedge clock) set_keys(k);
      @(negedge clock) set_keys(6'b0);
   endtask

   task automatic do_reset();
      @(negedge clock) resetn = 1'b1;
      @(negedge clock) resetn = 1'b0;
   endtask

   // Pulses key_place sampled at edge N; bit i of each mask is the output seen
   // during cycle N+i. Optionally pulses key_up / asserts reset during cycle N+k.
   task automatic run_place(input int up_at, input int rst_at,
                            output logic [9:0] det, output logic [9:0] wr,
                            output logic [9:0] ill, output logic [9:0] bsy,
                            output logic [9:0] go2);
      det = '0; wr = '0; ill = '0; bsy = '0; go2 = '0;
      @(negedge clock) set_keys(K_PLACE);
      for (int i = 1; i <= 9; i++) begin
         @(negedge clock);
         det[i] = detecten; wr[i] = writeen; ill[i] = illegal;
         bsy[i] = busy;     go2[i] = game_over2;
         if (i == 1)          set_keys(6'b0);
         if (i == up_at)      set_keys(K_UP);
         if (i == up_at + 1)  set_keys(6'b0);
         if (i == rst_at)     resetn = 1'b1;
         if (i == rst_at + 1) resetn = 1'b0;
      end
   endtask

   logic [9:0] det, wr, ill, bsy, go2;

   initial begin
      // reset state
      repeat (2) @(negedge clock);
      resetn = 1'b0;
      check("rst_x", 32'(x), 32'd3);
      check("rst_y", 32'(y), 32'd3);
      check("rst_side", 32'(side), 32'd2);
      check("rst_placed", 32'(placed), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      // cursor wrap and key priority
      repeat (4) press(K_LEFT);
      check("wrap_left_x", 32'(x), 32'd7);
      press(K_RIGHT);
      check("wrap_right_x", 32'(x), 32'd0);
      press(K_UP | K_DOWN);
      check("up_beats_down_y", 32'(y), 32'd2);

      // legal placement timing
      q = 2'd0; dir = 8'h04;
      run_place(0, 0, det, wr, ill, bsy, go2);
      check("legal_det_mask", 32'(det), 32'h00C);
      check("legal_wr_mask", 32'(wr), 32'h060);
      check("legal_ill_mask", 32'(ill), 32'h000);
      check("legal_busy_mask", 32'(bsy), 32'h0FE);
      check("legal_side", 32'(side), 32'd3);
      check("legal_placed", 32'(placed), 32'd1);

      // occupied cell
      q = 2'd2;
      run_place(0, 0, det, wr, ill, bsy, go2);
      check("occ_det_mask", 32'(det), 32'h000);
      check("occ_wr_mask", 32'(wr), 32'h000);
      check("occ_ill_mask", 32'(ill), 32'h004);
      check("occ_busy_mask", 32'(bsy), 32'h006);
      check("occ_side", 32'(side), 32'd3);

      // empty cell but no flips
      q = 2'd0; dir = 8'h00;
      run_place(0, 0, det, wr, ill, bsy, go2);
      check("nodir_det_mask", 32'(det), 32'h00C);
      check("nodir_wr_mask", 32'(wr), 32'h000);
      check("nodir_ill_mask", 32'(ill), 32'h020);
      check("nodir_busy_mask", 32'(bsy), 32'h03E);
      check("nodir_placed", 32'(placed), 32'd1);

      // pass, place, pass: placement clears the pass counter
      dir = 8'h81;
      press(K_PASS);
      check("pass_side", 32'(side), 32'd2);
      run_place(0, 0, det, wr, ill, bsy, go2);
      press(K_PASS);
      check("ppp_game_over", 32'(game_over), 32'd0);
      check("ppp_side", 32'(side), 32'd2);
      check("ppp_placed", 32'(placed), 32'd2);

      // MAX_PLACE = 2 instance reaches game over after its second placement
      do_reset();
      run_place(0, 0, det, wr, ill, bsy, go2);
      check("max2_first_go", 32'(go2), 32'h000);
      run_place(0, 0, det, wr, ill, bsy, go2);
      check("max2_second_go", 32'(go2), 32'h300);
      check("max2_placed", 32'(placed2), 32'd2);
      check("max60_not_over", 32'(game_over), 32'd0);

      // two consecutive passes end the game; keys then ignored
      press(K_PASS);
      press(K_PASS);
      check("pass2_game_over", 32'(game_over), 32'd1);
      check("pass2_side", 32'(side), 32'd2);
      press(K_LEFT);
      press(K_PLACE);
      repeat (3) @(negedge clock);
      check("over_x_frozen", 32'(x), 32'd3);
      check("over_busy", 32'(busy), 32'd0);
      check("over_placed", 32'(placed), 32'd2);

      // key dropped while busy, then reset during WR0
      do_reset();
      press(K_RIGHT);
      check("pre_x", 32'(x), 32'd4);
      run_place(3, 0, det, wr, ill, bsy, go2);
      check("drop_up_y", 32'(y), 32'd3);
      check("drop_up_wr_mask", 32'(wr), 32'h060);
      run_place(0, 5, det, wr, ill, bsy, go2);
      check("abort_wr_mask", 32'(wr), 32'h020);
      check("abort_x", 32'(x), 32'd3);
      check("abort_y", 32'(y), 32'd3);
      check("abort_side", 32'(side), 32'd2);
      check("abort_placed", 32'(placed), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);

      repeat (2) @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
